// File: rtl/neuron_spike_collector.sv
// neuron_spike_collector: gathers one spike bit per neuron from the
// time-multiplexed update engine into a 32-bit vector, then commits it to the
// spike-out block's external write port once no bus cycle is in progress.
module neuron_spike_collector #(
    parameter int NUM_NEURONS = 32,
    parameter int IDX_W       = 5
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   ts_start_i,
    input  logic                   ts_end_i,
    input  logic                   neuron_valid_i,
    input  logic [IDX_W-1:0]       neuron_idx_i,
    input  logic                   neuron_spike_i,
    output logic                   neuron_ready_o,
    input  logic                   bus_busy_i,
    output logic [NUM_NEURONS-1:0] spike_data_o,
    output logic                   spike_write_en_o,
    output logic                   ts_done_o,
    output logic [5:0]             spike_count_o,
    output logic                   busy_o,
    output logic                   err_dup_o,
    output logic                   err_ovr_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_NEURONS-1:0] vec_q, vec_d;
    logic [NUM_NEURONS-1:0] seen_q, seen_d;
    logic [NUM_NEURONS-1:0] spike_data_q, spike_data_d;
    logic [5:0]             spike_count_q, spike_count_d;
    logic                   write_en_q, write_en_d;
    logic                   err_dup_q, err_dup_d;
    logic                   err_ovr_q, err_ovr_d;

    logic                   accept;
    logic [5:0]             vec_popcnt;

    // Ready comes from registered state only, so it never depends on valid.
    assign accept = neuron_valid_i && (state_q == COLLECT);

    // Population count of the vector being committed.
    always_comb begin
        vec_popcnt = '0;
        for (int i = 0; i < NUM_NEURONS; i++)
            vec_popcnt = vec_popcnt + 6'(vec_q[i]);
    end

    // Next-state and datapath updates; a restart in COLLECT wins over both an
    // accept and ts_end, while a completing accept is applied before COMMIT.
    always_comb begin
        state_d       = state_q;
        vec_d         = vec_q;
        seen_d        = seen_q;
        spike_data_d  = spike_data_q;
        spike_count_d = spike_count_q;
        write_en_d    = 1'b0;
        err_dup_d     = err_dup_q;
        err_ovr_d     = err_ovr_q;
        unique case (state_q)
            IDLE: begin
                if (ts_start_i) begin
                    state_d   = COLLECT;
                    vec_d     = '0;
                    seen_d    = '0;
                    err_dup_d = 1'b0;
                    err_ovr_d = 1'b0;
                end
            end
            COLLECT: begin
                if (ts_start_i) begin
                    vec_d     = '0;
                    seen_d    = '0;
                    err_ovr_d = 1'b1;
                end else begin
                    if (accept) begin
                        if (seen_q[neuron_idx_i]) begin
                            err_dup_d = 1'b1;
                        end else begin
                            seen_d[neuron_idx_i] = 1'b1;
                            vec_d[neuron_idx_i]  = neuron_spike_i;
                        end
                    end
                    if ((&seen_d) || ts_end_i)
                        state_d = COMMIT;
                end
            end
            COMMIT: begin
                // A start here is dropped; the current vector still commits.
                if (ts_start_i)
                    err_ovr_d = 1'b1;
                // The spike-out block ignores external writes during a bus
                // cycle, so hold off until the bus is quiet.
                if (!bus_busy_i) begin
                    spike_data_d  = vec_q;
                    spike_count_d = vec_popcnt;
                    write_en_d    = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q       <= IDLE;
            vec_q         <= '0;
            seen_q        <= '0;
            spike_data_q  <= '0;
            spike_count_q <= '0;
            write_en_q    <= 1'b0;
            err_dup_q     <= 1'b0;
            err_ovr_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vec_q         <= vec_d;
            seen_q        <= seen_d;
            spike_data_q  <= spike_data_d;
            spike_count_q <= spike_count_d;
            write_en_q    <= write_en_d;
            err_dup_q     <= err_dup_d;
            err_ovr_q     <= err_ovr_d;
        end
    end

    assign neuron_ready_o   = (state_q == COLLECT);
    assign busy_o           = (state_q != IDLE);
    assign spike_data_o     = spike_data_q;
    assign spike_count_o    = spike_count_q;
    assign spike_write_en_o = write_en_q;
    assign ts_done_o        = write_en_q;
    assign err_dup_o        = err_dup_q;
    assign err_ovr_o        = err_ovr_q;

endmodule

// File: tb/tb_neuron_spike_collector.sv
// Directed bench for neuron_spike_collector: a table of full timesteps plus
// hand-written sequences for duplicate, restart, reset and bus-wait cases.
module tb_neuron_spike_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        ts_start, ts_end, nvalid, nspike, bus_busy;
    logic [4:0]  nidx;
    logic        nready, we, ts_done, busy, err_dup, err_ovr;
    logic [31:0] sdata;
    logic [5:0]  scount;

    int pass_cnt = 0;
    int total    = 0;
    int we_cnt   = 0;

    always #5 clk = ~clk;

    neuron_spike_collector #(.NUM_NEURONS(32), .IDX_W(5)) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .ts_start_i       (ts_start),
        .ts_end_i         (ts_end),
        .neuron_valid_i   (nvalid),
        .neuron_idx_i     (nidx),
        .neuron_spike_i   (nspike),
        .neuron_ready_o   (nready),
        .bus_busy_i       (bus_busy),
        .spike_data_o     (sdata),
        .spike_write_en_o (we),
        .ts_done_o        (ts_done),
        .spike_count_o    (scount),
        .busy_o           (busy),
        .err_dup_o        (err_dup),
        .err_ovr_o        (err_ovr)
    );

    // Strobe counter sampled on the falling edge.
    always @(negedge clk) if (we === 1'b1) we_cnt++;

    typedef struct {
        string       name;
        logic        desc;      // report indices 31..0 instead of 0..31
        logic        gap;       // idle cycle between reports
        logic [31:0] spikes;    // spike bit driven for each neuron
        int          busy_cyc;  // bus-busy edges seen while in COMMIT
        logic [31:0] exp_data;
        logic [5:0]  exp_cnt;
    } ts_vec_t;

    ts_vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ts_start = 1'b1;
        tick();
        ts_start = 1'b0;
    endtask

    task automatic accept(input logic [4:0] idx, input logic spk);
        nvalid = 1'b1;
        nidx   = idx;
        nspike = spk;
        tick();
        nvalid = 1'b0;
    endtask

    // One complete timestep driven from a table record.
    task automatic run_ts(input ts_vec_t v);
        logic [4:0] idx;
        int         w0;
        pulse_start();
        chk({v.name, " ready_in_collect"}, 32'(nready), 32'd1);
        chk({v.name, " busy_in_collect"}, 32'(busy), 32'd1);
        w0 = we_cnt;
        for (int k = 0; k < 32; k++) begin
            idx    = v.desc ? 5'(31 - k) : 5'(k);
            nvalid = 1'b1;
            nidx   = idx;
            nspike = v.spikes[idx];
            if (k == 31) bus_busy = (v.busy_cyc > 0);
            tick();
            nvalid = 1'b0;
            if (v.gap && k != 31) tick();
        end
        chk({v.name, " ready_in_commit"}, 32'(nready), 32'd0);
        chk({v.name, " no_strobe_at_last_accept"}, 32'(we), 32'd0);
        for (int b = 0; b < v.busy_cyc; b++) begin
            tick();
            chk({v.name, " no_strobe_while_busy"}, 32'(we), 32'd0);
            chk({v.name, " ready_low_while_busy"}, 32'(nready), 32'd0);
        end
        bus_busy = 1'b0;
        tick();
        chk({v.name, " strobe"}, 32'(we), 32'd1);
        chk({v.name, " ts_done"}, 32'(ts_done), 32'd1);
        chk({v.name, " data"}, sdata, v.exp_data);
        chk({v.name, " count"}, 32'(scount), 32'(v.exp_cnt));
        chk({v.name, " idle_after_commit"}, 32'(busy), 32'd0);
        tick();
        chk({v.name, " strobe_one_cycle"}, 32'(we), 32'd0);
        chk({v.name, " data_held"}, sdata, v.exp_data);
        chk({v.name, " one_strobe"}, 32'(we_cnt - w0), 32'd1);
        chk({v.name, " err_dup"}, 32'(err_dup), 32'd0);
        chk({v.name, " err_ovr"}, 32'(err_ovr), 32'd0);
    endtask

    initial begin
        int w0;
        tbl[0] = '{"asc_alt",   1'b0, 1'b0, 32'hAAAA_AAAA, 0, 32'hAAAA_AAAA, 6'd16};
        tbl[1] = '{"desc_gap",  1'b1, 1'b1, 32'h4000_0008, 0, 32'h4000_0008, 6'd2};
        tbl[2] = '{"busy5",     1'b0, 1'b0, 32'h0000_FFFF, 5, 32'h0000_FFFF, 6'd16};
        tbl[3] = '{"desc_none", 1'b1, 1'b0, 32'h0000_0000, 1, 32'h0000_0000, 6'd0};

        rst = 1'b1; ts_start = 1'b0; ts_end = 1'b0; nvalid = 1'b0;
        nspike = 1'b0; nidx = '0; bus_busy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst data", sdata, 32'd0);
        chk("rst count", 32'(scount), 32'd0);
        chk("rst outs", {26'd0, nready, we, ts_done, busy, err_dup, err_ovr}, 32'd0);

        // ts_end while idle does nothing.
        ts_end = 1'b1; tick(); ts_end = 1'b0;
        chk("idle_ts_end busy", 32'(busy), 32'd0);
        tick();
        chk("idle_ts_end strobe", 32'(we), 32'd0);

        for (int t = 0; t < 4; t++) run_ts(tbl[t]);

        // Duplicate report: first report kept, flag sticks through commit.
        pulse_start();
        accept(5'd7, 1'b1);
        chk("dup flag_before", 32'(err_dup), 32'd0);
        accept(5'd7, 1'b0);
        chk("dup flag", 32'(err_dup), 32'd1);
        ts_end = 1'b1; tick(); ts_end = 1'b0;
        chk("dup in_commit", 32'(busy & ~nready & ~we), 32'd1);
        tick();
        chk("dup strobe", 32'(we), 32'd1);
        chk("dup data", sdata, 32'h0000_0080);
        chk("dup count", 32'(scount), 32'd1);
        chk("dup flag_kept", 32'(err_dup), 32'd1);
        tick();

        // Completing accept together with ts_end: accept applied, one commit.
        pulse_start();
        w0 = we_cnt;
        for (int k = 0; k < 31; k++) accept(5'(k), 1'b1);
        ts_end = 1'b1;
        accept(5'd31, 1'b1);
        ts_end = 1'b0;
        chk("end_acc no_strobe_yet", 32'(we), 32'd0);
        tick();
        chk("end_acc data", sdata, 32'hFFFF_FFFF);
        chk("end_acc count", 32'(scount), 32'd32);
        tick();
        chk("end_acc one_strobe", 32'(we_cnt - w0), 32'd1);

        // Restart mid-collect clears the partial vector and flags overrun.
        pulse_start();
        w0 = we_cnt;
        for (int k = 0; k < 10; k++) accept(5'(k), 1'b0);
        pulse_start();
        chk("ovr flag", 32'(err_ovr), 32'd1);
        chk("ovr still_collect", 32'(nready), 32'd1);
        for (int k = 0; k < 32; k++) accept(5'(k), 1'b1);
        tick();
        chk("ovr data", sdata, 32'hFFFF_FFFF);
        chk("ovr count", 32'(scount), 32'd32);
        chk("ovr flag_kept", 32'(err_ovr), 32'd1);
        chk("ovr no_dup", 32'(err_dup), 32'd0);
        tick();
        chk("ovr one_strobe", 32'(we_cnt - w0), 32'd1);

        // Start during a bus-blocked COMMIT is dropped but flagged.
        pulse_start();
        bus_busy = 1'b1;
        ts_end = 1'b1; tick(); ts_end = 1'b0;
        pulse_start();
        chk("commit_start ovr", 32'(err_ovr), 32'd1);
        chk("commit_start busy", 32'(busy & ~nready), 32'd1);
        bus_busy = 1'b0;
        tick();
        chk("commit_start strobe", 32'(we), 32'd1);
        chk("commit_start data", sdata, 32'd0);
        tick();
        chk("commit_start dropped", 32'(busy), 32'd0);

        // Reset mid-collect: everything clears, no strobe issued.
        tbl[0].name = "after_rst";
        pulse_start();
        for (int k = 0; k < 20; k++) accept(5'(k), 1'b1);
        w0 = we_cnt;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst data", sdata, 32'd0);
        chk("midrst count", 32'(scount), 32'd0);
        chk("midrst outs", {26'd0, nready, we, ts_done, busy, err_dup, err_ovr}, 32'd0);
        tick(); tick(); tick();
        chk("midrst no_strobe", 32'(we_cnt - w0), 32'd0);
        run_ts(tbl[0]);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
